// File: rtl/voice_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : voice_mixer_pkg
// Purpose  : Shared constants for the voice mixer and its FIFO.
//            N_OSCILLATORS / FIXED_POINT mirror the oscillator build, so the
//            mixer's default parameters track the oscillator configuration.
// Revision : 1.0 - initial release
// ============================================================================
package voice_mixer_pkg;

  // Oscillator build constants (must match the oscillator instance).
  localparam int N_OSCILLATORS = 8;
  localparam int FIXED_POINT   = 8;

  // master_gain == 2**MIXER_GAIN_UNITY_SHIFT is unity gain.
  localparam int MIXER_GAIN_UNITY_SHIFT = 7;
  // DC blocker pole: y_prev leaks by y_prev >>> MIXER_DC_POLE_SHIFT per frame.
  localparam int MIXER_DC_POLE_SHIFT    = 8;

  // Accumulator width that holds the sum of n_voices samples without overflow.
  function automatic int mixer_acc_width(input int in_width, input int n_voices);
    return in_width + $clog2(n_voices) + 1;
  endfunction

endpackage : voice_mixer_pkg
`default_nettype wire

// File: rtl/voice_mixer_if.sv
`default_nettype none
// ============================================================================
// Interface : voice_mixer_if
// Purpose   : Valid/ready sample stream from the mixer to the audio output
//             stage (I2S / DAC serializer).
// Signals   : out_sample  signed OUT_WIDTH sample (head of the mixer FIFO)
//             out_valid   sample available
//             out_ready   consumer accepts the sample this cycle
// Modports  : master - mixer side, slave - consumer side
// Revision  : 1.0 - initial release
// ============================================================================
interface voice_mixer_if #(
  parameter int OUT_WIDTH = 24
);

  logic signed [OUT_WIDTH-1:0] out_sample;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output out_sample,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_sample,
    input  out_valid,
    output out_ready
  );

endinterface : voice_mixer_if
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sample_fifo
// Purpose  : Show-ahead synchronous FIFO for audio samples. The head entry is
//            visible on o_head whenever the FIFO is not empty (zero when
//            empty). A push while full is accepted only if a pop happens in
//            the same cycle; otherwise the push is ignored by the FIFO.
// Ports    : clk, rst      clock, synchronous active-high reset
//            i_push/i_data write request and data
//            i_pop         read request (ignored when empty)
//            o_head        head entry
//            o_full/o_empty/o_count  occupancy status
// Params   : WIDTH entry width, DEPTH entries (power of two, >= 2)
// Revision : 1.0 - initial release
// ============================================================================
module sample_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  wire logic                          clk,
  input  wire logic                          rst,
  input  wire logic                          i_push,
  input  wire logic [WIDTH-1:0]              i_data,
  input  wire logic                          i_pop,
  output logic      [WIDTH-1:0]              o_head,
  output logic                               o_full,
  output logic                               o_empty,
  output logic      [$clog2(DEPTH+1)-1:0]    o_count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_count == c_depth);
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !w_empty;
  // When full, a same-cycle pop frees the slot being written (wr == rd).
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; the empty mask on o_head hides stale contents.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule : sample_fifo
`default_nettype wire

// File: rtl/voice_mixer.sv
`default_nettype none
// ============================================================================
// Module   : voice_mixer
// Purpose  : Sums the per-voice oscillator samples of one index sweep into a
//            frame, scales it by master_gain, saturates it to OUT_WIDTH and
//            queues it in a small FIFO for the audio output stage.
//            Pipeline: close (T) -> scaled (T+1) -> saturated/push (T+2)
//            -> out_valid (T+3, FIFO previously empty).
// Ports    : clk, rst        clock, synchronous active-high reset
//            enable          freezes accumulation and frame close when low
//            index           voice index shared with the oscillator
//            sample          oscillator output for the current index
//            master_gain     unsigned gain, 128 = unity
//            clear_flags     clears overrun / overrun_count
//            stream          voice_mixer_if master (out_sample/valid/ready)
//            clip            pulse: frame being pushed was saturated
//            overrun         sticky: a frame was dropped on a full FIFO
//            overrun_count   dropped frames, saturating at 0xFFFF
// Config   : VOICE_MIXER_DC_BLOCK_EN - adds a one-pole DC blocker after the
//            saturation stage (same latency).
// Revision : 1.0 - initial release
// ============================================================================
module voice_mixer
  import voice_mixer_pkg::*;
#(
  parameter int N_VOICES   = N_OSCILLATORS,
  parameter int IN_WIDTH   = 24 + FIXED_POINT,
  parameter int OUT_WIDTH  = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic                              clk,
  input  wire logic                              rst,
  input  wire logic                              enable,
  input  wire logic [$clog2(N_VOICES+1)-1:0]     index,
  input  wire logic signed [IN_WIDTH-1:0]        sample,
  input  wire logic [7:0]                        master_gain,
  input  wire logic                              clear_flags,
  voice_mixer_if.master                          stream,
  output logic                                   clip,
  output logic                                   overrun,
  output logic [15:0]                            overrun_count
);

  localparam int c_idx_w       = $clog2(N_VOICES + 1);
  localparam int c_acc_w       = mixer_acc_width(IN_WIDTH, N_VOICES);
  localparam int c_prod_w      = c_acc_w + 9;
  localparam int c_scale_shift = MIXER_GAIN_UNITY_SHIFT + FIXED_POINT;
  localparam int c_cnt_w       = $clog2(FIFO_DEPTH + 1);

  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N_VOICES);

  localparam logic signed [c_prod_w-1:0] c_sat_max =
    {{(c_prod_w-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [c_prod_w-1:0] c_sat_min =
    {{(c_prod_w-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // --------------------------------------------------------------------------
  // Accumulate and frame close
  // --------------------------------------------------------------------------
  logic signed [c_acc_w-1:0] r_acc;
  logic                      r_idx_last;
  logic signed [c_acc_w-1:0] w_sample_ext;
  logic                      w_is_last;
  logic                      w_in_sweep;
  logic                      w_close;

  assign w_sample_ext = c_acc_w'(sample);
  assign w_is_last    = (index == c_last_idx);
  assign w_in_sweep   = (index < c_last_idx);
  // Only the first cycle of index == N_VOICES closes a frame; index values
  // above N_VOICES neither accumulate nor close.
  assign w_close      = enable && w_is_last && !r_idx_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_idx_last <= 1'b0;
    end else begin
      r_idx_last <= w_is_last;
      if (enable) begin
        if (w_close) begin
          r_acc <= '0;
        end else if (w_in_sweep) begin
          r_acc <= r_acc + w_sample_ext;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: gain scaling (gain captured together with the frame)
  // --------------------------------------------------------------------------
  logic signed [8:0]          w_gain_s;
  logic signed [c_prod_w-1:0] w_prod;
  logic signed [c_prod_w-1:0] r_s1_scaled;
  logic                       r_s1_valid;

  assign w_gain_s = {1'b0, master_gain};
  assign w_prod   = c_prod_w'(r_acc) * c_prod_w'(w_gain_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_scaled <= '0;
    end else begin
      r_s1_valid <= w_close;
      if (w_close) begin
        r_s1_scaled <= w_prod >>> c_scale_shift;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: saturation (and optional DC blocker)
  // --------------------------------------------------------------------------
  logic                        w_sat_hi;
  logic                        w_sat_lo;
  logic signed [OUT_WIDTH-1:0] w_sat_x;
  logic                        w_sat_clip;
  logic signed [OUT_WIDTH-1:0] w_s2_data;
  logic                        w_s2_clip;

  assign w_sat_hi   = (r_s1_scaled > c_sat_max);
  assign w_sat_lo   = (r_s1_scaled < c_sat_min);
  assign w_sat_clip = w_sat_hi || w_sat_lo;
  assign w_sat_x    = w_sat_hi ? c_sat_max[OUT_WIDTH-1:0] :
                      w_sat_lo ? c_sat_min[OUT_WIDTH-1:0] :
                                 r_s1_scaled[OUT_WIDTH-1:0];

`ifdef VOICE_MIXER_DC_BLOCK_EN
  // y = x - x_prev + y_prev - (y_prev >>> pole); the two guard bits keep the
  // intermediate sum exact for full-scale steps before re-saturation.
  localparam int c_dc_w = OUT_WIDTH + 2;
  localparam logic signed [c_dc_w-1:0] c_dc_max =
    {{(c_dc_w-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [c_dc_w-1:0] c_dc_min =
    {{(c_dc_w-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [OUT_WIDTH-1:0] r_x_prev;
  logic signed [c_dc_w-1:0]    r_y_prev;
  logic signed [c_dc_w-1:0]    w_y_full;
  logic                        w_y_hi;
  logic                        w_y_lo;

  assign w_y_full  = c_dc_w'(w_sat_x) - c_dc_w'(r_x_prev) + r_y_prev
                     - (r_y_prev >>> MIXER_DC_POLE_SHIFT);
  assign w_y_hi    = (w_y_full > c_dc_max);
  assign w_y_lo    = (w_y_full < c_dc_min);
  assign w_s2_data = w_y_hi ? c_dc_max[OUT_WIDTH-1:0] :
                     w_y_lo ? c_dc_min[OUT_WIDTH-1:0] :
                              w_y_full[OUT_WIDTH-1:0];
  assign w_s2_clip = w_sat_clip || w_y_hi || w_y_lo;

  // Filter state advances on every pushed frame, even one the FIFO drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_prev <= '0;
      r_y_prev <= '0;
    end else if (r_s1_valid) begin
      r_x_prev <= w_sat_x;
      r_y_prev <= c_dc_w'(w_s2_data);
    end
  end
`else
  assign w_s2_data = w_sat_x;
  assign w_s2_clip = w_sat_clip;
`endif

  logic                        r_s2_valid;
  logic signed [OUT_WIDTH-1:0] r_s2_data;
  logic                        r_s2_clip;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_clip  <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_clip  <= r_s1_valid && w_s2_clip;
      if (r_s1_valid) begin
        r_s2_data <= w_s2_data;
      end
    end
  end

  assign clip = r_s2_clip;

  // --------------------------------------------------------------------------
  // Output FIFO and overrun tracking
  // --------------------------------------------------------------------------
  logic [OUT_WIDTH-1:0] w_fifo_head;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [c_cnt_w-1:0]   w_fifo_count;
  logic                 w_pop;
  logic                 w_drop;

  sample_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_sample_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_s2_valid),
    .i_data  (r_s2_data),
    .i_pop   (w_pop),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_pop  = stream.out_ready && !w_fifo_empty;
  assign w_drop = r_s2_valid && w_fifo_full && !w_pop;

  assign stream.out_valid  = (w_fifo_count != '0);
  assign stream.out_sample = w_fifo_head;

  logic        r_overrun;
  logic [15:0] r_overrun_count;

  // clear_flags wins over a drop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun       <= 1'b0;
      r_overrun_count <= '0;
    end else if (clear_flags) begin
      r_overrun       <= 1'b0;
      r_overrun_count <= '0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
      if (r_overrun_count != 16'hFFFF) begin
        r_overrun_count <= r_overrun_count + 16'd1;
      end
    end
  end

  assign overrun       = r_overrun;
  assign overrun_count = r_overrun_count;

endmodule : voice_mixer
`default_nettype wire

// File: tb/tb_voice_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_voice_mixer
// Purpose  : Self-checking bench for voice_mixer with default parameters
//            (8 voices, 32-bit samples with 8 fractional bits, 24-bit out,
//            4-entry FIFO). Table of single-frame vectors plus hand-written
//            sequences for back-pressure, flag priority, reset mid-frame,
//            held index / enable, and the DC blocker build option.
// Revision : 1.0 - initial release
// ============================================================================
module tb_voice_mixer;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic [3:0]         index;
  logic signed [31:0] sample;
  logic [7:0]         master_gain;
  logic               clear_flags;
  logic               clip;
  logic               overrun;
  logic [15:0]        overrun_count;

  voice_mixer_if #(.OUT_WIDTH(24)) stream ();

  voice_mixer dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .index         (index),
    .sample        (sample),
    .master_gain   (master_gain),
    .clear_flags   (clear_flags),
    .stream        (stream),
    .clip          (clip),
    .overrun       (overrun),
    .overrun_count (overrun_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [31:0] voices [8];

  typedef struct {
    logic signed [31:0] v01;      // voices 0 and 1
    logic signed [31:0] vrest;    // voices 2..7
    logic [7:0]         gain;
    logic signed [23:0] exp_sample;
    logic               exp_clip;
  } vec_t;

  vec_t tab [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    index = 4'd0;
    sample = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_voices(input logic signed [31:0] v01, input logic signed [31:0] vrest);
    for (int i = 0; i < 8; i++) begin
      voices[i] = (i < 2) ? v01 : vrest;
    end
  endtask

  // Sweeps index 0..7 then presents index 8 for one sampled cycle (frame
  // close). Returns 1 time unit after the edge that sampled the close, with
  // index left held at 8.
  task automatic sweep();
    for (int i = 0; i < 8; i++) begin
      index  = 4'(i);
      sample = voices[i];
      tick();
    end
    index  = 4'd8;
    sample = '0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_valid;
    logic signed [23:0] dc_exp [3];

    rst = 1'b1;
    enable = 1'b1;
    index = '0;
    sample = '0;
    master_gain = 8'd128;
    clear_flags = 1'b0;
    stream.out_ready = 1'b1;

    // Values in the voice columns are integers << 8 (FIXED_POINT = 8).
    tab[0]  = '{32'sd256000,        32'sd0,        8'd128, 24'sd2000,     1'b0};
    tab[1]  = '{32'sh7FFFFFFF,      32'sh7FFFFFFF, 8'd255, 24'sd8388607,  1'b1};
    tab[2]  = '{32'sh80000000,      32'sh80000000, 8'd255, -24'sd8388608, 1'b1};
    tab[3]  = '{-32'sd128000,       32'sd0,        8'd128, -24'sd1000,    1'b0};
    tab[4]  = '{32'sd256000,        32'sd0,        8'd64,  24'sd1000,     1'b0};
    tab[5]  = '{32'sd256000,        32'sd0,        8'd255, 24'sd3984,     1'b0};
    tab[6]  = '{-32'sd256000,       32'sd0,        8'd255, -24'sd3985,    1'b0};
    tab[7]  = '{32'sd256000,        32'sd0,        8'd0,   24'sd0,        1'b0};
    tab[8]  = '{32'sd1073741696,    32'sd0,        8'd128, 24'sd8388607,  1'b0};
    tab[9]  = '{32'sd1073741824,    32'sd0,        8'd128, 24'sd8388607,  1'b1};
    tab[10] = '{32'sd0,             32'sd25600,    8'd128, 24'sd600,      1'b0};

    do_reset();
    check("reset_valid", stream.out_valid, 0);
    check("reset_sample", stream.out_sample, 0);
    check("reset_clip", clip, 0);
    check("reset_overrun", overrun, 0);
    check("reset_overrun_count", overrun_count, 0);

    // ---------------- table-driven single frames ----------------
    for (int v = 0; v < 11; v++) begin
      do_reset();
      stream.out_ready = 1'b1;
      master_gain = tab[v].gain;
      set_voices(tab[v].v01, tab[v].vrest);
      sweep();                          // close sampled (T)
      tick();                           // T+2: push + clip
      check($sformatf("tab%0d_clip", v), clip, tab[v].exp_clip);
      check($sformatf("tab%0d_valid_early", v), stream.out_valid, 0);
      tick();                           // T+3
      check($sformatf("tab%0d_valid", v), stream.out_valid, 1);
      check($sformatf("tab%0d_sample", v), stream.out_sample, tab[v].exp_sample);
      tick();                           // popped
      check($sformatf("tab%0d_valid_after", v), stream.out_valid, 0);
    end

    // ---------------- back-pressure ----------------
    do_reset();
    master_gain = 8'd128;
    stream.out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      set_voices(32'sd0, 32'sd0);
      voices[0] = 32'(k) <<< 8;
      sweep();
      if (k == 4) begin
        tick(); tick(); tick();
        check("bp_no_overrun_at_4", overrun, 0);
      end
    end
    tick(); tick(); tick();
    check("bp_overrun", overrun, 1);
    check("bp_overrun_count", overrun_count, 1);
    check("bp_head_held", stream.out_sample, 1);
    tick();
    check("bp_head_stable", stream.out_sample, 1);
    stream.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("bp_valid_%0d", k), stream.out_valid, 1);
      check($sformatf("bp_order_%0d", k), stream.out_sample, k);
      tick();
    end
    check("bp_drained", stream.out_valid, 0);
    check("bp_overrun_sticky", overrun, 1);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("bp_clear_overrun", overrun, 0);
    check("bp_clear_count", overrun_count, 0);

    // ---------------- clear_flags vs same-cycle drop ----------------
    stream.out_ready = 1'b0;
    set_voices(32'sd0, 32'sd0);
    voices[0] = 32'sd2304;              // 9
    for (int k = 0; k < 4; k++) sweep();
    sweep();
    tick();                             // fifth frame's push is presented now
    clear_flags = 1'b1;
    tick();                             // drop and clear on the same edge
    clear_flags = 1'b0;
    check("prio_overrun", overrun, 0);
    check("prio_count", overrun_count, 0);
    sweep();
    tick(); tick(); tick();
    check("prio_next_drop_overrun", overrun, 1);
    check("prio_next_drop_count", overrun_count, 1);

    // ---------------- reset mid-frame ----------------
    stream.out_ready = 1'b1;
    index = 4'd0; sample = 32'sd256000; tick();
    index = 4'd1; sample = 32'sd256000; tick();
    index = 4'd2; sample = 32'sd256000; rst = 1'b1; tick();
    rst = 1'b0;
    index = 4'd0; sample = '0;
    check("rstmid_valid", stream.out_valid, 0);
    check("rstmid_sample", stream.out_sample, 0);
    check("rstmid_clip", clip, 0);
    check("rstmid_overrun", overrun, 0);
    check("rstmid_count", overrun_count, 0);
    set_voices(32'sd0, 32'sd0);
    voices[0] = 32'sd1792;              // 7
    sweep();
    tick(); tick();
    check("rstmid_next_valid", stream.out_valid, 1);
    check("rstmid_next_sample", stream.out_sample, 7);

    // ---------------- held index / enable ----------------
    do_reset();
    stream.out_ready = 1'b1;
    set_voices(32'sd0, 32'sd0);
    voices[0] = 32'sd768;               // 3
    sweep();
    n_valid = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (stream.out_valid) n_valid++;
    end
    check("held_frames", n_valid, 1);
    enable = 1'b0;
    sweep();
    sweep();
    n_valid = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (stream.out_valid) n_valid++;
    end
    check("disabled_frames", n_valid, 0);
    enable = 1'b1;
    voices[0] = 32'sd1280;              // 5
    sweep();
    tick(); tick();
    check("reenable_sample", stream.out_sample, 5);

    // ---------------- DC blocker / steady output ----------------
`ifdef VOICE_MIXER_DC_BLOCK_EN
    dc_exp[0] = 24'sd1000; dc_exp[1] = 24'sd997;  dc_exp[2] = 24'sd994;
`else
    dc_exp[0] = 24'sd1000; dc_exp[1] = 24'sd1000; dc_exp[2] = 24'sd1000;
`endif
    do_reset();
    stream.out_ready = 1'b1;
    master_gain = 8'd128;
    set_voices(32'sd0, 32'sd0);
    voices[0] = 32'sd256000;            // 1000
    for (int f = 0; f < 3; f++) begin
      sweep();
      tick(); tick();
      check($sformatf("dc_valid_%0d", f), stream.out_valid, 1);
      check($sformatf("dc_sample_%0d", f), stream.out_sample, dc_exp[f]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_voice_mixer
`default_nettype wire

// File: doc/voice_mixer.md
# voice_mixer

Downstream of the time-multiplexed `oscillator`. It accumulates the per-voice `out` samples presented during one index sweep into a single mixed frame. The frame is scaled by a master gain and saturated to the output width, then buffered in a small FIFO. A valid/ready handshake hands each frame to the audio output stage (I2S/DAC serializer). One frame is produced per sweep of `index` over `0..N_VOICES`.

## Interface
Parameters:
- `N_VOICES`, default `` `N_OSCILLATORS ``: voices per sweep.
- `IN_WIDTH`, default `` 24 + `FIXED_POINT ``: signed oscillator sample width, with `FIXED_POINT` fractional bits.
- `OUT_WIDTH`, default `24`: signed integer output sample width.
- `FIFO_DEPTH`, default `4`: output FIFO entries (power of two).

Ports:
- `clk`  in  1  sample-domain clock, shared with `oscillator`.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  when low, the accumulator and frame close are frozen; the FIFO still drains.
- `index`  in  `$clog2(N_VOICES+1)`  same index bus that drives `oscillator`.
- `sample`  in  `IN_WIDTH` signed  `oscillator.out` for the current `index`.
- `master_gain`  in  8  unsigned; 128 = unity, 255 ≈ ×1.99.
- `clear_flags`  in  1  clears `overrun` and `overrun_count`.
- `out_sample`  out  `OUT_WIDTH` signed  head of the FIFO.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `clip`  out  1  one-cycle pulse when the frame being pushed was saturated.
- `overrun`  out  1  sticky; set when a frame is dropped because the FIFO was full.
- `overrun_count`  out  16  dropped frames, saturating at 0xFFFF.

## Operation
- **Accumulate.** While `enable` is high and `index < N_VOICES`: `acc <= acc + sample`. `acc` is `IN_WIDTH + $clog2(N_VOICES) + 1` bits signed and cannot overflow.
- **Frame close.** A frame closes on the first cycle with `index == N_VOICES` and `enable` high, where the previous registered index was not `N_VOICES`. On that cycle, `acc` is captured into stage 1 and `acc` is reset to 0. Repeated `index == N_VOICES` cycles do not close extra frames. `index > N_VOICES` is ignored.
- **Stage 1 (scale).** `scaled = (frame * master_gain) >>> (7 + FIXED_POINT)`, arithmetic shift. `master_gain` is sampled at frame close.
- **Stage 2 (saturate).** Clamp to `[-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]`. `clip` is 1 if clamping occurred. The result is pushed into the FIFO.
- **FIFO.** A pop occurs when `out_valid && out_ready`.
  - Push while full: the frame is dropped, `overrun` is set, and `overrun_count` increments.
  - Simultaneous push and pop while full: the push succeeds and nothing is dropped.
- **Flag priority.** `clear_flags` takes priority over a same-cycle overrun event.
- **Reset values.** `rst` clears `acc`, the pipeline valids, the FIFO pointers and count, the DC state, and all flags. Outputs after reset: `out_valid=0`, `out_sample=0`, `clip=0`, `overrun=0`, `overrun_count=0`. If reset is asserted mid-frame, the partial frame is discarded.

## Timing
- Frame close at cycle T: stage 1 is registered at T+1, the FIFO write completes at T+2, and `out_valid` rises at T+3 if the FIFO was empty.
- `clip` pulses at T+2, together with the push.
- `out_sample` is registered from the FIFO head and stays stable while `out_valid && !out_ready`.
- Throughput is one frame per `N_VOICES+1` cycles. The pipeline never stalls; back-pressure is absorbed only by the FIFO.

## Configuration
- `VOICE_MIXER_DC_BLOCK_EN` defined: stage 2 adds a DC blocker after saturation.
  - Filter: `y = x - x_prev + y_prev - (y_prev >>> 8)`, with state `OUT_WIDTH+2` bits wide.
  - `y` is re-saturated to `OUT_WIDTH`; `clip` ORs both saturations.
  - State updates only on pushed frames, including frames later dropped by the FIFO.
  - Latency is unchanged; the filter shares the stage 2 register.
- Undefined: `x` goes straight to the FIFO, and no DC state exists.

## Structure
- `N_OSCILLATORS` and `FIXED_POINT` come from `constants.svh`.
- Add `MIXER_GAIN_UNITY_SHIFT` (7) and `MIXER_DC_POLE_SHIFT` (8) to `constants.svh`.
- No new package types are needed.
- One sub-module, `sample_fifo` (parameterised width and depth, show-ahead, with full/empty/count), reusable by the I2S stage.

## Test plan
- **Basic mix.** Voices 0 and 1 each `1000<<FIXED_POINT`, others 0, gain 128, `out_ready=1` → `out_sample=2000`, `out_valid` for 1 cycle at T+3, `clip=0`.
- **Saturation.** All voices at `2^(IN_WIDTH-1)-1`, gain 255 → `out_sample=8388607`, `clip=1`. All voices at the minimum value → `-8388608`, `clip=1`.
- **Back-pressure.** `out_ready=0` for 5 frames of values 1..5 → `overrun=1`, `overrun_count=1`. After raising `out_ready`: 1, 2, 3, 4 in order, then `out_valid=0`. `clear_flags` → both flags 0.
- **Reset mid-frame.** `rst` asserted during voice 2 of a frame → that frame is never output. The next full frame is correct, and all outputs read 0 in the cycle after reset.
- **Held index.** `index` held at `N_VOICES` for 10 cycles → exactly one frame is pushed. With `enable=0`, sweeps produce no frames.
- **DC block.** With `VOICE_MIXER_DC_BLOCK_EN`, constant input 1000 per frame → outputs 1000, 997, 994, …. Without the macro, the output is steady at 1000.
